// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder/subtractor.
// Stage count and per-stage slice widths are derived here so the top and bench agree.
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int stages_f(input int width, input int seg);
      return (width + seg - 1) / seg;
   endfunction

   // The last slice takes whatever bits remain, so it may be narrower than seg.
   function automatic int slice_w_f(input int width, input int seg, input int k);
      return ((width - k * seg) < seg) ? (width - k * seg) : seg;
   endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub.
// Both sides use valid/ready: a beat moves on a rising edge where valid && ready; valid holds until then.
interface pipelined_addsub_if #(
   parameter int WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

endinterface

// File: rtl/pipelined_addsub_slice.sv
// One pipeline stage: adds one operand slice plus incoming carry and registers sum, carry, valid.
// ovf_q is the signed-overflow flag of this slice's top bit; only the final slice's copy is meaningful.
module addsub_slice #(
   parameter int SW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          v_in,
   input  logic          c_in,
   input  logic [SW-1:0] a_s,
   input  logic [SW-1:0] b_s,
   output logic          v_q,
   output logic          c_q,
   output logic          ovf_q,
   output logic [SW-1:0] s_q
);

   logic [SW:0] total;

   assign total = {1'b0, a_s} + {1'b0, b_s} + {{SW{1'b0}}, c_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= 1'b0;
         c_q   <= 1'b0;
         ovf_q <= 1'b0;
         s_q   <= '0;
      end else if (en) begin
         v_q   <= v_in;
         c_q   <= total[SW];
         ovf_q <= (a_s[SW-1] == b_s[SW-1]) && (total[SW-1] != a_s[SW-1]);
         s_q   <= total[SW-1:0];
      end
   end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: one SEG-bit ripple slice per stage, valid/ready on both sides.
// Subtraction is a + ~b + !cin, so cout=1 means "no borrow".
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEG   = 4
) (
   input logic                clk,
   input logic                rst_n,
   pipelined_addsub_if.slave  bus
);

   localparam int STAGES = stages_f(WIDTH, SEG);

   logic             adv;
   // w[k]: word entering stage k; slices below k already hold results, the rest still hold operand a.
   logic [WIDTH-1:0] w  [STAGES+1];
   logic [WIDTH-1:0] bw [STAGES];
   logic             c  [STAGES+1];
   logic             v  [STAGES+1];
   logic             ov [STAGES];

   // Whole pipe moves together; a bubble at the output never blocks it.
   assign adv          = bus.out_ready || !bus.out_valid;
   assign bus.in_ready = adv;

   assign w[0]  = bus.a;
   assign bw[0] = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
   assign c[0]  = bus.cin ^ (bus.sub == OP_SUB);
   assign v[0]  = bus.in_valid;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int               LO   = k * SEG;
      localparam int               SW   = slice_w_f(WIDTH, SEG, k);
      localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - SW)) << LO;

      logic [WIDTH-1:0] w_q;
      logic [SW-1:0]    s_q;

      addsub_slice #(.SW(SW)) u_slice (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (adv),
         .v_in  (v[k]),
         .c_in  (c[k]),
         .a_s   (w[k][LO+SW-1:LO]),
         .b_s   (bw[k][LO+SW-1:LO]),
         .v_q   (v[k+1]),
         .c_q   (c[k+1]),
         .ovf_q (ov[k]),
         .s_q   (s_q)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            w_q <= '0;
         end else if (adv) begin
            w_q <= w[k];
         end
      end

      assign w[k+1] = (w_q & ~MASK) | (WIDTH'(s_q) << LO);

      // Operand b only needs to travel as far as the last slice that consumes it.
      if (k < STAGES - 1) begin : g_b
         logic [WIDTH-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               b_q <= '0;
            end else if (adv) begin
               b_q <= bw[k];
            end
         end

         assign bw[k+1] = b_q;
      end
   end

   assign bus.out_valid = v[STAGES];
   assign bus.sum       = w[STAGES];
   assign bus.cout      = c[STAGES];
   assign bus.ovf       = ov[STAGES-1];

endmodule
